// File: rtl/reimu_bullet_ctrl_pkg.sv
// Shared definitions for the player bullet controller: FSM encoding,
// default frame timing parameters and bullet/boss geometry constants.
package reimu_bullet_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FLY   = 2'd2,
        ST_COOL  = 2'd3
    } bullet_state_t;

    // Default bullet rise per frame, cooldown length and frame-tick line
    localparam int unsigned DEF_SPEED       = 6;
    localparam int unsigned DEF_COOL_FRAMES = 8;
    localparam int unsigned DEF_TICK_LINE   = 480;

    // Bullet sprite half-size and spawn distance above the player centre
    localparam int unsigned BULLET_HALF  = 7;
    localparam int unsigned SPAWN_OFFSET = 33;

    // Collision window half-extents around the boss centre
    localparam int unsigned HIT_HALF_W = 32;
    localparam int unsigned HIT_HALF_H = 45;

    // Magnitude of a - b computed in 11 bits so screen coordinates never wrap
    function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[10] ? 11'(-d) : 11'(d);
    endfunction

endpackage

// File: rtl/reimu_bullet_ctrl_fire_sync.sv
// Two-flop synchronizer for the raw fire button plus a rising-edge pulse
// derived from the synchronized level.
module fire_sync (
    input  logic clk_25m,
    input  logic rst,
    input  logic fire,
    output logic fire_rise
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // Resynchronize the button into clk_25m and keep one delayed copy for edge detection
    always_ff @(posedge clk_25m or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= fire;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign fire_rise = sync_q2 & ~sync_q3;

endmodule

// File: rtl/reimu_bullet_ctrl.sv
// Player bullet controller: accepts a fire press, spawns a bullet above the
// player on the next frame tick, moves it up once per frame, and detects
// boss collisions. All position/state changes happen on the frame tick so
// the pixel mux never sees a change during active video.
module reimu_bullet_ctrl
    import reimu_bullet_ctrl_pkg::*;
#(
    parameter int unsigned SPEED       = DEF_SPEED,
    parameter int unsigned COOL_FRAMES = DEF_COOL_FRAMES,
    parameter int unsigned TICK_LINE   = DEF_TICK_LINE
) (
    input  logic       clk_25m,
    input  logic       rst,
    input  logic       fire,
    input  logic [9:0] reimux,
    input  logic [9:0] reimuy,
    input  logic       reimuE,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic       boss,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    output logic [9:0] reimu_bulletx,
    output logic [9:0] reimu_bullety,
    output logic       reimu_bullet,
    output logic       hit
);

    localparam logic [9:0] TICK_VC   = 10'(TICK_LINE);
    localparam logic [9:0] STEP_Y    = 10'(SPEED);
    localparam logic [9:0] EXIT_Y    = 10'(SPEED + BULLET_HALF);
    localparam logic [9:0] SPAWN_DY  = 10'(SPAWN_OFFSET);
    localparam logic [3:0] COOL_INIT = 4'(COOL_FRAMES - 1);

    bullet_state_t state;
    logic [3:0]    cool_cnt;
    logic          fire_rise;
    logic          frame_tick;
    logic          collide;

    fire_sync u_fire_sync (
        .clk_25m   (clk_25m),
        .rst       (rst),
        .fire      (fire),
        .fire_rise (fire_rise)
    );

    assign frame_tick = (hc == '0) && (vc == TICK_VC);

    // Overlap test uses the current (pre-move) bullet position
    assign collide = boss
                  && (abs_diff11(reimu_bulletx, bossx) <= 11'(HIT_HALF_W))
                  && (abs_diff11(reimu_bullety, bossy) <= 11'(HIT_HALF_H));

    // Bullet lifecycle FSM with registered position, presence and hit outputs
    always_ff @(posedge clk_25m or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            reimu_bulletx <= '0;
            reimu_bullety <= '0;
            reimu_bullet  <= 1'b0;
            hit           <= 1'b0;
            cool_cnt      <= '0;
        end else begin
            hit <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fire_rise && reimuE) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (frame_tick) begin
                        if (reimuE) begin
                            state         <= ST_FLY;
                            reimu_bulletx <= reimux;
                            reimu_bullety <= (reimuy >= SPAWN_DY) ? (reimuy - SPAWN_DY) : '0;
                            reimu_bullet  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FLY: begin
                    if (frame_tick) begin
                        if (collide) begin
                            hit          <= 1'b1;
                            reimu_bullet <= 1'b0;
                            cool_cnt     <= COOL_INIT;
                            state        <= ST_COOL;
                        end else if (reimu_bullety <= EXIT_Y) begin
                            reimu_bullet <= 1'b0;
                            cool_cnt     <= COOL_INIT;
                            state        <= ST_COOL;
                        end else begin
                            reimu_bullety <= reimu_bullety - STEP_Y;
                        end
                    end
                end
                ST_COOL: begin
                    if (frame_tick) begin
                        if (cool_cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            cool_cnt <= cool_cnt - 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reimu_bullet_ctrl.sv
// Scoreboard bench for reimu_bullet_ctrl. The stimulus drives hc/vc directly
// to produce frame ticks and queues the expected post-tick outputs; a monitor
// pops one expectation per tick and also checks hit stays low elsewhere.
module tb_reimu_bullet_ctrl;

    typedef struct {
        logic       b;
        logic [9:0] x;
        logic [9:0] y;
        logic       h;
        logic       cxy;
    } exp_t;

    logic       clk_25m = 1'b0;
    logic       rst     = 1'b0;
    logic       fire    = 1'b0;
    logic [9:0] reimux  = '0;
    logic [9:0] reimuy  = '0;
    logic       reimuE  = 1'b0;
    logic [9:0] bossx   = '0;
    logic [9:0] bossy   = '0;
    logic       boss    = 1'b0;
    logic [9:0] hc      = 10'd5;
    logic [9:0] vc      = '0;
    logic [9:0] reimu_bulletx;
    logic [9:0] reimu_bullety;
    logic       reimu_bullet;
    logic       hit;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_tick = 0;
    exp_t exp_q[$];

    reimu_bullet_ctrl #(
        .SPEED       (6),
        .COOL_FRAMES (8),
        .TICK_LINE   (480)
    ) dut (
        .clk_25m       (clk_25m),
        .rst           (rst),
        .fire          (fire),
        .reimux        (reimux),
        .reimuy        (reimuy),
        .reimuE        (reimuE),
        .bossx         (bossx),
        .bossy         (bossy),
        .boss          (boss),
        .hc            (hc),
        .vc            (vc),
        .reimu_bulletx (reimu_bulletx),
        .reimu_bullety (reimu_bullety),
        .reimu_bullet  (reimu_bullet),
        .hit           (hit)
    );

    always #5 clk_25m = ~clk_25m;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s (tick %0d): actual %0d, required %0d", name, n_tick, act, req);
        end
    endtask

    task automatic do_tick(input logic b, input int x, input int y, input logic h, input logic cxy);
        exp_t e;
        e.b = b; e.x = 10'(x); e.y = 10'(y); e.h = h; e.cxy = cxy;
        exp_q.push_back(e);
        @(posedge clk_25m); #1;
        hc = 10'd0; vc = 10'd480;
        @(posedge clk_25m); #1;
        hc = 10'd5; vc = 10'd0;
        @(posedge clk_25m); #1;
    endtask

    task automatic press_fire();
        @(posedge clk_25m); #1;
        fire = 1'b1;
        repeat (4) @(posedge clk_25m);
        #1 fire = 1'b0;
        repeat (4) @(posedge clk_25m);
        #1;
    endtask

    task automatic cool_wait();
        repeat (8) do_tick(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_bullet"}, 32'(reimu_bullet), 0);
        cmp({tag, "_x"}, 32'(reimu_bulletx), 0);
        cmp({tag, "_y"}, 32'(reimu_bullety), 0);
        cmp({tag, "_hit"}, 32'(hit), 0);
    endtask

    // Monitor: one expectation per observed frame tick, hit low otherwise
    initial begin
        exp_t e;
        logic t;
        forever begin
            @(posedge clk_25m);
            t = (hc == 10'd0) && (vc == 10'd480) && rst;
            @(negedge clk_25m);
            if (t) begin
                n_tick++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tick (tick %0d): actual queue empty, required an expectation", n_tick);
                end else begin
                    e = exp_q.pop_front();
                    cmp("bullet", 32'(reimu_bullet), 32'(e.b));
                    cmp("hit", 32'(hit), 32'(e.h));
                    if (e.cxy) begin
                        cmp("bullet_x", 32'(reimu_bulletx), 32'(e.x));
                        cmp("bullet_y", 32'(reimu_bullety), 32'(e.y));
                    end
                end
            end else begin
                cmp("hit_outside_tick", 32'(hit), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual stimulus still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_25m);
        #1 check_zero("reset");
        rst = 1'b1;

        // Straight shot: spawn at (320,367), rise 6/frame to y=13, then despawn
        reimux = 10'd320; reimuy = 10'd400; reimuE = 1'b1; boss = 1'b0;
        press_fire();
        do_tick(1'b1, 320, 367, 1'b0, 1'b1);
        // Near-miss raster positions must not move the bullet
        @(posedge clk_25m); #1 hc = 10'd1; vc = 10'd480;
        @(posedge clk_25m); #1 hc = 10'd0; vc = 10'd479;
        @(posedge clk_25m); #1 hc = 10'd5; vc = 10'd0;
        press_fire();
        for (int k = 1; k <= 59; k++) do_tick(1'b1, 320, 367 - 6 * k, 1'b0, 1'b1);
        do_tick(1'b0, 0, 0, 1'b0, 1'b0);
        press_fire();
        repeat (7) do_tick(1'b0, 0, 0, 1'b0, 1'b0);
        press_fire();
        do_tick(1'b0, 0, 0, 1'b0, 1'b0);

        // Spawn near top saturates to y=0 and despawns on the next tick
        reimux = 10'd100; reimuy = 10'd20;
        press_fire();
        do_tick(1'b1, 100, 0, 1'b0, 1'b1);
        do_tick(1'b0, 0, 0, 1'b0, 1'b0);
        cool_wait();

        // Boss hit at (320,200): first pre-move y<=245 is 241; reimuE drop mid-flight is harmless
        reimux = 10'd320; reimuy = 10'd400; boss = 1'b1; bossx = 10'd320; bossy = 10'd200;
        press_fire();
        do_tick(1'b1, 320, 367, 1'b0, 1'b1);
        for (int k = 1; k <= 21; k++) begin
            if (k == 5) reimuE = 1'b0;
            do_tick(1'b1, 320, 367 - 6 * k, 1'b0, 1'b1);
        end
        reimuE = 1'b1;
        do_tick(1'b0, 0, 0, 1'b1, 1'b0);
        cool_wait();

        // |dx|=33 misses all the way to the top
        bossx = 10'd353;
        press_fire();
        do_tick(1'b1, 320, 367, 1'b0, 1'b1);
        for (int k = 1; k <= 59; k++) do_tick(1'b1, 320, 367 - 6 * k, 1'b0, 1'b1);
        do_tick(1'b0, 0, 0, 1'b0, 1'b0);
        cool_wait();

        // |dx|=32 hits
        bossx = 10'd352;
        press_fire();
        do_tick(1'b1, 320, 367, 1'b0, 1'b1);
        for (int k = 1; k <= 21; k++) do_tick(1'b1, 320, 367 - 6 * k, 1'b0, 1'b1);
        do_tick(1'b0, 0, 0, 1'b1, 1'b0);
        cool_wait();

        // Boss drops on the overlapping tick: no hit, bullet moves; boss back -> hit
        bossx = 10'd320;
        press_fire();
        do_tick(1'b1, 320, 367, 1'b0, 1'b1);
        for (int k = 1; k <= 21; k++) do_tick(1'b1, 320, 367 - 6 * k, 1'b0, 1'b1);
        boss = 1'b0;
        do_tick(1'b1, 320, 235, 1'b0, 1'b1);
        boss = 1'b1;
        do_tick(1'b0, 0, 0, 1'b1, 1'b0);
        cool_wait();

        // Far-apart x (10 vs 1020) must not alias into a hit
        reimux = 10'd10; bossx = 10'd1020;
        press_fire();
        do_tick(1'b1, 10, 367, 1'b0, 1'b1);
        for (int k = 1; k <= 25; k++) do_tick(1'b1, 10, 367 - 6 * k, 1'b0, 1'b1);

        // Asynchronous reset mid-flight, between clock edges
        @(negedge clk_25m); #2;
        rst = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk_25m);
        #1 rst = 1'b1;
        reimux = 10'd200; reimuy = 10'd300; boss = 1'b0;
        press_fire();
        do_tick(1'b1, 200, 267, 1'b0, 1'b1);
        do_tick(1'b1, 200, 261, 1'b0, 1'b1);
        @(posedge clk_25m); #1 rst = 1'b0;
        @(posedge clk_25m); #1 rst = 1'b1;

        // No player: fire dropped; player vanishes while armed -> back to idle
        reimuE = 1'b0;
        press_fire();
        do_tick(1'b0, 0, 0, 1'b0, 1'b0);
        reimuE = 1'b1;
        press_fire();
        reimuE = 1'b0;
        do_tick(1'b0, 0, 0, 1'b0, 1'b0);
        reimuE = 1'b1;
        do_tick(1'b0, 0, 0, 1'b0, 1'b0);
        press_fire();
        do_tick(1'b1, 200, 267, 1'b0, 1'b1);

        repeat (4) @(posedge clk_25m);
        #1 cmp("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reimu_bullet_ctrl.md
REIMU_BULLET_CTRL -- requirements
Module: reimu_bullet_ctrl

Interface
REQ-001 Parameter SPEED, 6, bullet rise in pixels per frame.
REQ-002 Parameter COOL_FRAMES, 8, frames after despawn/hit before next fire accepted.
REQ-003 Parameter TICK_LINE, 480, vc value at which the frame tick occurs (first blanking line).
REQ-004 Port clk_25m  in  1  pixel clock; the single clock.
REQ-005 Port rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 Port fire  in  1  raw player fire button, asynchronous, active-high.
REQ-007 Port reimux, reimuy  in  10 each  player centre.
REQ-008 Port reimuE  in  1  player exists.
REQ-009 Port bossx, bossy  in  10 each  boss centre.
REQ-010 Port boss  in  1  boss exists.
REQ-011 Port hc, vc  in  10 each  raster counters from the sync generator.
REQ-012 Port reimu_bulletx, reimu_bullety  out  10 each  bullet centre, to the pixel mux.
REQ-013 Port reimu_bullet  out  1  bullet exists, to the pixel mux.
REQ-014 Port hit  out  1  one-cycle pulse on bullet/boss collision.

Function
REQ-015 frame_tick SHALL be 1 for exactly the cycle where hc==0 and vc==TICK_LINE; all position/state updates except fire capture SHALL occur only on frame_tick, so outputs never change during active video.
REQ-016 fire SHALL pass a 2-FF synchronizer; a rising edge SHALL be detected on the synchronized signal (2-cycle sync latency, +1 edge).
REQ-017 FSM states: IDLE, ARMED, FLY, COOL.
REQ-018 IDLE: fire edge with reimuE==1 -> ARMED next cycle; edges with reimuE==0 dropped.
REQ-019 ARMED: on frame_tick, if reimuE==1 -> FLY with x=reimux, y=reimuy-33, reimu_bullet=1; if reimuE==0 -> IDLE.
REQ-020 FLY, on frame_tick, priority order: (a) collision -> hit=1 for that cycle, reimu_bullet=0, -> COOL; (b) y<=SPEED+7 -> reimu_bullet=0, -> COOL; (c) else y=y-SPEED, x unchanged.
REQ-021 Collision SHALL be boss==1 and |x-bossx|<=32 and |y-bossy|<=45, evaluated on the pre-update position using 11-bit signed differences (no 10-bit wrap).
REQ-022 COOL: 4-bit counter loaded with COOL_FRAMES-1 on entry, decremented per frame_tick; at 0 on frame_tick -> IDLE.
REQ-023 Fire edges in ARMED, FLY, COOL SHALL be ignored (no queuing).
REQ-024 Spawn with reimuy<33: y SHALL saturate to 0 and bullet SHALL despawn on the next frame_tick via rule (b).
REQ-025 reimuE falling during FLY SHALL NOT affect the bullet.
REQ-026 boss deasserting in the same tick as overlap: no hit; rule (b)/(c) apply.
REQ-027 hit SHALL be registered, never asserted outside a frame_tick cycle.

Reset
REQ-028 rst==0 SHALL immediately force state=IDLE, reimu_bulletx=0, reimu_bullety=0, reimu_bullet=0, hit=0, cool counter=0, synchronizer and edge flops=0.
REQ-029 Reset mid-flight SHALL discard the bullet; first fire edge after release SHALL be handled as from IDLE.

Structure
REQ-030 Shared package SHALL hold the state encoding (2-bit), SPEED, COOL_FRAMES, TICK_LINE, bullet sprite half-size (7) and spawn offset (33).
REQ-031 One sub-module fire_sync (2-FF synchronizer + rising-edge pulse) SHALL be instantiated; all else inline.

Verification
REQ-032 Fire edge at reimux=320, reimuy=400, boss=0 -> at next frame_tick bullet=1 at (320,367); following ticks y=361,355,...
REQ-033 Continue REQ-032 to y=13 -> next tick bullet=0, state COOL; fire during the 8 COOL frames ignored; fire after -> new spawn.
REQ-034 boss=1 at (320,200), bullet rising from (320,367) -> hit pulse exactly once, on the first tick with y<=245, bullet=0 that cycle.
REQ-035 bossx=353, bullet x=320 (|dx|=33) -> no hit, bullet exits top; bossx=352 -> hit.
REQ-036 rst=0 asserted mid-flight, between ticks -> outputs 0 without waiting for a clock edge; fire after release spawns normally.
REQ-037 Fire while reimuE=0, and reimuE dropped in ARMED -> no spawn, state returns IDLE.
